// File: rtl/timer_pkg.sv
// timer_pkg: shared mode encodings and default sizes for the multi_timer slice
package timer_pkg;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;
  localparam int   DEF_N_CH      = 4;
  localparam int   DEF_WIDTH     = 16;
endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: per-channel control/status bundle for multi_timer
//   en/restart/mode  N_CH-bit controls, one bit per channel
//   times/cnt        N_CH*WIDTH packed, channel k in [k*WIDTH +: WIDTH]
//   tc/done          N_CH-bit status
//   master = user side, slave = timer side
interface multi_timer_if
  import timer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIDTH = DEF_WIDTH
) ();
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       restart;
  logic [N_CH-1:0]       mode;
  logic [N_CH*WIDTH-1:0] times;
  logic [N_CH*WIDTH-1:0] cnt;
  logic [N_CH-1:0]       tc;
  logic [N_CH-1:0]       done;
  modport master (output en, restart, mode, times, input cnt, tc, done);
  modport slave  (input en, restart, mode, times, output cnt, tc, done);
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one WIDTH-bit counter with periodic/one-shot terminal handling
//   clk, reset_n (async active-low), tick (count strobe)
//   en, restart, mode, times -> cnt, tc (en && cnt==last), done (sticky one-shot flag)
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             en,
  input  logic             restart,
  input  logic             mode,
  input  logic [WIDTH-1:0] times,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             done
);
  logic [WIDTH-1:0] cnt_q, cnt_d, last;
  logic             done_q, done_d, adv, at_end;
  always_comb begin
    // times==0 underflows to all-ones, giving the full-range count
    last   = times - 1'b1;
    adv    = en && tick && !restart;
    // >= rather than == so a period lowered below cnt still terminates next tick
    at_end = cnt_q >= last;
    cnt_d  = restart ? '0 : !adv ? cnt_q : !at_end ? cnt_q + 1'b1 :
             mode == MODE_ONESHOT ? cnt_q : '0;
    done_d = restart ? 1'b0 : (adv && at_end && mode == MODE_ONESHOT) ? 1'b1 : done_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign cnt  = cnt_q;
  assign tc   = en && cnt_q == last;
  assign done = done_q;
endmodule

// File: rtl/multi_timer.sv
// multi_timer: N_CH independent counter/timer channels sharing one optional prescaler
//   clk, reset_n (async active-low), bus (multi_timer_if.slave)
//   TIMER_PRESCALE_EN: when defined, adds PRESCALE and a free-running divider that
//   gates the count tick; otherwise every clk is a tick.
module multi_timer
  import timer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIDTH = DEF_WIDTH
`ifdef TIMER_PRESCALE_EN
  , parameter int PRESCALE = 1
`endif
) (
  input logic          clk,
  input logic          reset_n,
  multi_timer_if.slave bus
);
  logic tick;
`ifdef TIMER_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  always_comb begin
    tick  = pre_q == PW'(PRESCALE - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= '0;
    else pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .en     (bus.en[c]),
      .restart(bus.restart[c]),
      .mode   (bus.mode[c]),
      .times  (bus.times[c*WIDTH +: WIDTH]),
      .cnt    (bus.cnt[c*WIDTH +: WIDTH]),
      .tc     (bus.tc[c]),
      .done   (bus.done[c])
    );
  end
endmodule
